// File: rtl/hh_mon_pkg.sv
// hh_mon_pkg: shared states, report layout and flag positions for the spike monitor
package hh_mon_pkg;
  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;
  localparam logic [1:0] BYTE_CNT = 2'd0, BYTE_ISI_HI = 2'd1, BYTE_ISI_LO = 2'd2, BYTE_FLAGS = 2'd3;
  localparam int FLG_FIRST = 0, FLG_CSAT = 1, FLG_ISAT = 2, FLG_OVR = 3;
  typedef struct packed {
    logic [7:0]  cnt;
    logic [15:0] isi;
    logic [7:0]  flags;
  } report_t;
  function automatic logic [7:0] report_byte(report_t r, logic [1:0] idx);
    return idx == BYTE_CNT ? r.cnt : idx == BYTE_ISI_HI ? r.isi[15:8] : idx == BYTE_ISI_LO ? r.isi[7:0] : r.flags;
  endfunction
endpackage

// File: rtl/hh_spike_monitor_if.sv
// hh_spike_monitor_if: report byte stream with valid/ready handshake
interface hh_spike_monitor_if;
  logic       valid;
  logic       last;
  logic       ready;
  logic [7:0] data;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/hh_spike_sync.sv
// hh_spike_sync: synchronises the asynchronous spike line and emits a 1-cycle pulse per rising edge
module hh_spike_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic spk_evt
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, evt_q, evt_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], spike_in};
    prev_d = sync_q[SYNC_STAGES-1];
    evt_d  = sync_q[SYNC_STAGES-1] & ~prev_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end
  assign spk_evt = evt_q;
endmodule

// File: rtl/hh_spike_monitor.sv
// hh_spike_monitor: counts spikes per window, measures inter-spike interval, streams 4-byte reports
module hh_spike_monitor
  import hh_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int ISI_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic spike_in,
  output logic overrun,
  hh_spike_monitor_if.master rpt
);
  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  logic spk_evt, ev, term, take, drop, b3_acc, clr_ovr, busy;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d, isi_inc, last_isi_q, last_isi_d;
  logic [7:0] spk_cnt_q, spk_cnt_d, cnt_inc;
  logic first_seen_q, first_seen_d, ovr_pend_q, ovr_pend_d, overrun_q, overrun_d;
  logic [15:0] isi16;
  report_t rep_q, rep_d, snap;
  state_t state_q, state_d;

  hh_spike_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spk_evt(spk_evt)
  );

  // ISI counts the event cycle itself, so a period of N cycles reports N
  always_comb begin
    ev           = spk_evt & ena;
    term         = ena && win_cnt_q == WIN_W'(WINDOW_CYCLES - 1);
    isi_inc      = &isi_cnt_q ? isi_cnt_q : isi_cnt_q + ISI_W'(1);
    cnt_inc      = ev && !(&spk_cnt_q) ? spk_cnt_q + 8'd1 : spk_cnt_q;
    isi_cnt_d    = !ena ? isi_cnt_q : ev ? '0 : isi_inc;
    last_isi_d   = ev && first_seen_q ? isi_inc : last_isi_q;
    first_seen_d = first_seen_q | ev;
    win_cnt_d    = !ena ? win_cnt_q : term ? '0 : win_cnt_q + WIN_W'(1);
    spk_cnt_d    = term ? '0 : cnt_inc;
  end

  generate
    if (ISI_W > 16) begin : g_isi_trunc
      assign isi16 = last_isi_d[ISI_W-1 -: 16];
    end else begin : g_isi_ext
      assign isi16 = 16'(last_isi_d);
    end
  endgenerate

  // a snapshot is only accepted when the frame buffer is free this cycle
  always_comb begin
    b3_acc                = state_q == S_B3 && rpt.ready;
    take                  = term && (state_q == S_IDLE || b3_acc);
    drop                  = term && !take;
    clr_ovr               = b3_acc && rep_q.flags[FLG_OVR];
    ovr_pend_d            = (ovr_pend_q && !clr_ovr) || drop;
    overrun_d             = overrun_q || drop;
    snap.cnt              = cnt_inc;
    snap.isi              = isi16;
    snap.flags            = '0;
    snap.flags[FLG_FIRST] = first_seen_d;
    snap.flags[FLG_CSAT]  = &cnt_inc;
    snap.flags[FLG_ISAT]  = &isi_cnt_q || &last_isi_d;
    snap.flags[FLG_OVR]   = ovr_pend_q && !clr_ovr;
    rep_d                 = take ? snap : rep_q;
    state_d               = (state_q == S_IDLE || b3_acc) ? (take ? S_B0 : S_IDLE)
                          : rpt.ready ? state_t'(state_q + 3'd1) : state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q    <= '0;
      isi_cnt_q    <= '0;
      last_isi_q   <= '0;
      spk_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      ovr_pend_q   <= 1'b0;
      overrun_q    <= 1'b0;
      rep_q        <= '0;
      state_q      <= S_IDLE;
    end else begin
      win_cnt_q    <= win_cnt_d;
      isi_cnt_q    <= isi_cnt_d;
      last_isi_q   <= last_isi_d;
      spk_cnt_q    <= spk_cnt_d;
      first_seen_q <= first_seen_d;
      ovr_pend_q   <= ovr_pend_d;
      overrun_q    <= overrun_d;
      rep_q        <= rep_d;
      state_q      <= state_d;
    end
  end

  assign busy      = state_q != S_IDLE;
  assign rpt.valid = busy;
  assign rpt.data  = busy ? report_byte(rep_q, 2'(state_q - 3'd1)) : 8'd0;
  assign rpt.last  = state_q == S_B3;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_hh_spike_monitor.sv
// tb_hh_spike_monitor: randomized scenarios checked cycle by cycle against a timestamp-based reference model
module tb_hh_spike_monitor;
  localparam int W = 600;
  localparam int IW = 8;
  localparam int SS = 2;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, spike_in = 1'b0;
  logic overrun;
  hh_spike_monitor_if rpt();
  hh_spike_monitor #(.WINDOW_CYCLES(W), .ISI_W(IW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .overrun(overrun), .rpt(rpt.master)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int e, n, last_e, last_isi, rem, m_rem;
  bit first, pend, ovr, cur_b3, h1, h2, h3, h4;
  logic [7:0] cur [4];
  logic s_valid, s_last, s_ovr, m_valid, m_last, m_ovr;
  logic [7:0] s_data, m_data;
  logic [7:0] rx [$];

  task automatic model_reset();
    e = 0; n = 0; last_e = -1; last_isi = 0; rem = 0; m_rem = 0;
    first = 0; pend = 0; ovr = 0; cur_b3 = 0;
    {h1, h2, h3, h4} = 4'b0;
    rx.delete();
  endtask

  // drive one cycle, sample outputs mid-cycle, then advance the model over that cycle
  task automatic step(input bit sp, input bit en, input bit rd);
    bit ev, term, clr, isat;
    int run;
    @(posedge clk); #1;
    spike_in = sp; ena = en; rpt.ready = rd;
    @(negedge clk);
    s_valid = rpt.valid; s_data = rpt.data; s_last = rpt.last; s_ovr = overrun;
    if (s_valid && rd) rx.push_back(s_data);
    m_rem = rem; m_valid = rem > 0; m_data = rem > 0 ? cur[4-rem] : 8'h00; m_last = rem == 1; m_ovr = ovr;
    ev = en && h3 && !h4;
    {h4, h3, h2, h1} = {h3, h2, h1, sp};
    term = en && (e % W == W - 1);
    run = e - last_e - 1;
    if (ev) begin
      n++;
      if (first) last_isi = (e - last_e) > 255 ? 255 : e - last_e;
      first = 1; last_e = e;
    end
    clr = rem == 1 && rd && cur_b3;
    pend = pend && !clr;
    if (rem > 0 && rd) rem--;
    if (term) begin
      isat = run >= 255 || last_isi == 255;
      if (rem == 0) begin
        cur[0] = n > 255 ? 8'hFF : 8'(n);
        cur[1] = 8'h00;
        cur[2] = 8'(last_isi);
        cur[3] = {4'b0, pend, isat, n >= 255, first};
        cur_b3 = pend; rem = 4;
      end else begin
        pend = 1; ovr = 1;
      end
      n = 0;
    end
    if (en) e++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; spike_in = 1'b0; ena = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    if (rpt.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rpt.valid); end
    checks++;
    if (rpt.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rpt.data); end
    checks++;
    if (rpt.last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", rpt.last); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++;
    apply_reset();
  endtask

  task automatic test_periodic();
    int w = 1;
    rx.delete();
    for (int c = 0; c < 1810; c++) begin
      if (c % 10 == 0) w = $urandom_range(1, 5);
      step(c % 10 < w, 1, 1);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL periodic c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
    if (rx.size() < 4 || {rx[$-3], rx[$-2], rx[$-1], rx[$]} !== 32'h3C000A01) begin
      errors++; $display("FAIL periodic_frame got %0d bytes, exp last frame 3c000a01", rx.size());
    end
    checks++;
  endtask

  task automatic test_idle();
    rx.delete();
    for (int c = 0; c < 1810; c++) begin
      step(0, 1, 1);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL idle c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
    if (rx.size() < 4 || {rx[$-3], rx[$-1], rx[$]} !== 24'h000A05) begin
      errors++; $display("FAIL idle_frame got %0d bytes, exp cnt 00 isi 0a flags 05", rx.size());
    end
    checks++;
  endtask

  task automatic test_saturate();
    rx.delete();
    while (e % W != 0) begin
      step(0, 1, 1);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL sat_align got v%b l%b o%b d%h exp v%b l%b o%b d%h", s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
    for (int c = 0; c < 610; c++) begin
      step(c < 600 && c % 2 == 0, 1, 1);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL saturate c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
    if (rx.size() < 4 || {rx[$-3], rx[$-1], rx[$]} !== 24'hFF0203) begin
      errors++; $display("FAIL saturate_frame got %0d bytes, exp cnt ff isi 02 flags 03", rx.size());
    end
    checks++;
  endtask

  task automatic test_ena_freeze();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) == 0, c < 100 || c >= 300, 1);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL ena_freeze c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
  endtask

  task automatic test_overrun();
    for (int c = 0; c < 1300; c++) begin
      step($urandom_range(0, 4) == 0, 1, 0);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL overrun_hold c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", overrun); end
    checks++;
    rx.delete();
    for (int c = 0; c < 1810; c++) begin
      step($urandom_range(0, 4) == 0, 1, 1);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL overrun_drain c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
    if (rx.size() < 12 || rx[7][3] !== 1'b1 || rx[11][3] !== 1'b0) begin
      errors++; $display("FAIL overrun_frames got %0d bytes, exp frame1 b3=1 and frame2 b3=0", rx.size());
    end
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2400; c++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0);
      if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
        errors++;
        $display("FAIL random c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step(k % 10 == 0, 1, 1);
      found = m_rem == 3;
    end
    if (!found) begin
      errors++; $display("FAIL reset_mid_wait got no B1 within 2000 cycles exp B1");
    end else begin
      rst_n = 1'b0; spike_in = 1'b0; ena = 1'b0;
      #1;
      if ({rpt.valid, rpt.last, overrun, rpt.data} !== 11'd0) begin
        errors++; $display("FAIL reset_mid_outputs got v%b l%b o%b d%h exp all 0", rpt.valid, rpt.last, overrun, rpt.data);
      end
      checks++;
      apply_reset();
      for (int c = 0; c < 700; c++) begin
        step($urandom_range(0, 2) == 0, 1, 1);
        if ({s_valid, s_last, s_ovr, s_data} !== {m_valid, m_last, m_ovr, m_data}) begin
          errors++;
          $display("FAIL reset_mid c=%0d got v%b l%b o%b d%h exp v%b l%b o%b d%h", c, s_valid, s_last, s_ovr, s_data, m_valid, m_last, m_ovr, m_data);
        end
        checks++;
      end
      if (rx.size() < 4 || rx[3][3] !== 1'b0) begin
        errors++; $display("FAIL reset_mid_frame got %0d bytes, exp first frame with b3=0", rx.size());
      end
      checks++;
    end
  endtask

  initial begin
    rpt.ready = 1'b0;
    test_reset();
    test_periodic();
    test_idle();
    test_saturate();
    test_ena_freeze();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
